jtbubl_scan2x: RTL

//  Line doubler that sits directly downstream of the video stage: it consumes
//  the 15 kHz RGB444 stream (red/green/blue, LHBL, LVBL, HS, VS at pxl_cen).
//  It emits each line twice at pxl2_cen, giving ~31 kHz output for VGA.
//  Two ping-pong line buffers: one is written at 1x while the other is read at 2x.

---
 rtl/jtbubl_scan2x.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/jtbubl_scan2x.sv
// jtbubl_scan2x -- 15 kHz to 31 kHz line doubler for RGB444 video.
//
// Each input line is written at the pixel rate into one half of a ping-pong
// line buffer. The other half, which holds the previous complete line, is read
// out twice at double rate. With en=0 the inputs are copied straight to the
// outputs on pxl_cen. The buffers are still written in that mode, so doubling
// can resume cleanly.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   pxl_cen, pxl2_cen   1x input / 2x output clock enables (pxl2_cen is set
//                       whenever pxl_cen is set)
//   en                  1 = line doubling, 0 = registered bypass
//   red_in/green_in/blue_in, LHBL, LVBL, HS, VS   input video at 1x
//   red/green/blue, LHBL_dbl, LVBL_dbl, HS_dbl, VS_dbl   output video at 2x
module jtbubl_scan2x #(
  parameter int unsigned HLEN = 384,
  parameter int unsigned AW   = 9,
  parameter int unsigned HSW  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       pxl2_cen,
  input  logic       en,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic       HS,
  input  logic       VS,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dbl,
  output logic       LVBL_dbl,
  output logic       HS_dbl,
  output logic       VS_dbl
);

  localparam logic [AW-1:0] WR_MAX  = '1;
  localparam logic [AW-1:0] RD_LAST = AW'(HLEN - 1);
  localparam logic [AW-1:0] HS_END  = AW'(HSW);

  // Both banks live in one array; the bank bit is the address MSB.
  logic [12:0] mem [2**(AW+1)];

  // Write side
  logic          hs_last_q;
  logic          bank_q,   bank_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]    lines_q,  lines_d;
  logic          mode_q;
  logic          hs_edge;

  // Read side
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [12:0]   rd_word;
  logic          valid;
  logic          use_dbl;

  // Output registers
  logic [11:0]   rgb_q,  rgb_d;
  logic          lhbl_q, lhbl_d;
  logic          lvbl_q, lvbl_d;
  logic          hs_q,   hs_d;
  logic          vs_q,   vs_d;

  assign hs_edge = pxl_cen & HS & ~hs_last_q;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    bank_d   = bank_q;
    lines_d  = lines_q;
    if (hs_edge) begin
      wr_cnt_d = '0;
      bank_d   = ~bank_q;
      if (lines_q != 2'd2) lines_d = lines_q + 2'd1;
    end else if (wr_cnt_q != WR_MAX) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_last_q <= 1'b0;
      wr_cnt_q  <= '0;
      bank_q    <= 1'b0;
      lines_q   <= '0;
      mode_q    <= 1'b0;
    end else if (pxl_cen) begin
      hs_last_q <= HS;
      wr_cnt_q  <= wr_cnt_d;
      bank_q    <= bank_d;
      lines_q   <= lines_d;
      mode_q    <= en;
    end
  end

  // The pixel present on an HS edge still lands at the current address in the
  // bank being closed; the new bank starts with the following pixel.
  always_ff @(posedge clk) begin
    if (pxl_cen) mem[{bank_q, wr_cnt_q}] <= {LHBL, red_in, green_in, blue_in};
  end

  // HS edge restarts the reader, overriding both increment and wrap.
  always_comb begin
    if (hs_edge)                 rd_cnt_d = '0;
    else if (rd_cnt_q == RD_LAST) rd_cnt_d = '0;
    else                          rd_cnt_d = rd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rd_cnt_q <= '0;
    else if (pxl2_cen) rd_cnt_q <= rd_cnt_d;
  end

  assign rd_word = mem[{~bank_q, rd_cnt_q}];
  assign valid   = (lines_q == 2'd2);

  // A pxl_cen cycle applies the freshly sampled en; cycles with only pxl2_cen
  // follow the mode sampled on the last pxl_cen.
  assign use_dbl = pxl_cen ? en : mode_q;

  always_comb begin
    rgb_d  = rgb_q;
    lhbl_d = lhbl_q;
    lvbl_d = lvbl_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (pxl_cen && !en) begin
      rgb_d  = {red_in, green_in, blue_in};
      lhbl_d = LHBL;
      lvbl_d = LVBL;
      hs_d   = HS;
      vs_d   = VS;
    end else if (pxl2_cen && use_dbl) begin
      lhbl_d = rd_word[12] & valid;
      // Vertical signals only move when the reader restarts a line.
      if (rd_cnt_d == '0) begin
        lvbl_d = LVBL;
        vs_d   = VS;
      end
      hs_d  = (rd_cnt_q < HS_END);
      // Blanking uses the next flag values so rgb and flags change together.
      rgb_d = (lhbl_d && lvbl_d) ? rd_word[11:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      lhbl_q <= 1'b0;
      lvbl_q <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      lhbl_q <= lhbl_d;
      lvbl_q <= lvbl_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
  assign LHBL_dbl = lhbl_q;
  assign LVBL_dbl = lvbl_q;
  assign HS_dbl   = hs_q;
  assign VS_dbl   = vs_q;

endmodule
